// File: rtl/ray_slice_sequencer_if.sv
// Request/result channel between the slice sequencer and the shared ray/distance datapath.
// The sequencer is the master; the datapath is the slave.
interface ray_slice_sequencer_if;
    logic       slice_valid;
    logic       slice_ready;
    logic [7:0] slice_index;
    logic [8:0] ray_angle_int;
    logic [9:0] ray_angle_frac;
    logic       result_valid;

    modport master (
        output slice_valid,
        output slice_index,
        output ray_angle_int,
        output ray_angle_frac,
        input  slice_ready,
        input  result_valid
    );

    modport slave (
        input  slice_valid,
        input  slice_index,
        input  ray_angle_int,
        input  ray_angle_frac,
        output slice_ready,
        output result_valid
    );
endinterface

// File: rtl/ray_slice_sequencer.sv
// Per-frame column scheduler: sweeps every screen slice once per frame, one outstanding request at a
// time, stepping the ray angle incrementally as whole degrees plus thousandths.
module ray_slice_sequencer #(
    parameter int NUM_SLICES = 160,
    parameter int FOV_DEG    = 60,
    parameter int STEP_INT   = 0,
    parameter int STEP_FRAC  = 375,
    parameter int FRAC_SCALE = 1000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         frame_start,
    input  logic [8:0]                   player_angle,
    output logic                         busy,
    output logic                         frame_done,
    ray_slice_sequencer_if.master        slice_bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [9:0]  HALF_FOV     = 10'(FOV_DEG / 2);
    localparam logic [9:0]  FULL_CIRCLE  = 10'd360;
    localparam logic [9:0]  STEP_INT_W   = 10'(STEP_INT);
    localparam logic [10:0] STEP_FRAC_W  = 11'(STEP_FRAC);
    localparam logic [10:0] FRAC_SCALE_W = 11'(FRAC_SCALE);
    localparam logic [7:0]  LAST_SLICE   = 8'(NUM_SLICES - 1);

    state_t     state_r;
    logic       slice_valid_r;
    logic [7:0] slice_index_r;
    logic [8:0] ray_int_r;
    logic [9:0] ray_frac_r;
    logic       busy_r;
    logic       frame_done_r;

    logic [9:0]  player_ext_s;
    logic [8:0]  start_angle_s;
    logic [10:0] frac_sum_s;
    logic [9:0]  frac_next_s;
    logic        carry_s;
    logic [9:0]  int_sum_s;
    logic [8:0]  int_next_s;

    // First-slice angle and the one-step angle advance (fraction carry into the degree, then mod 360).
    always_comb begin
        player_ext_s = {1'b0, player_angle};
        if (player_ext_s < HALF_FOV) begin
            start_angle_s = 9'(player_ext_s + FULL_CIRCLE - HALF_FOV);
        end else begin
            start_angle_s = 9'(player_ext_s - HALF_FOV);
        end

        frac_sum_s = {1'b0, ray_frac_r} + STEP_FRAC_W;
        if (frac_sum_s >= FRAC_SCALE_W) begin
            frac_next_s = 10'(frac_sum_s - FRAC_SCALE_W);
            carry_s     = 1'b1;
        end else begin
            frac_next_s = frac_sum_s[9:0];
            carry_s     = 1'b0;
        end

        int_sum_s = {1'b0, ray_int_r} + STEP_INT_W + {9'd0, carry_s};
        if (int_sum_s >= FULL_CIRCLE) begin
            int_next_s = 9'(int_sum_s - FULL_CIRCLE);
        end else begin
            int_next_s = int_sum_s[8:0];
        end
    end

    // Sweep FSM with all outputs registered; reset overrides everything, even mid-frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            slice_valid_r <= 1'b0;
            slice_index_r <= 8'd0;
            ray_int_r     <= 9'd0;
            ray_frac_r    <= 10'd0;
            busy_r        <= 1'b0;
            frame_done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    frame_done_r <= 1'b0;
                    if (frame_start) begin
                        state_r       <= ST_ISSUE;
                        slice_valid_r <= 1'b1;
                        busy_r        <= 1'b1;
                        slice_index_r <= 8'd0;
                        ray_int_r     <= start_angle_s;
                        ray_frac_r    <= 10'd0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (slice_bus.slice_ready) begin
                        state_r       <= ST_WAIT;
                        slice_valid_r <= 1'b0;
                    end else begin
                        state_r <= ST_ISSUE;
                    end
                end
                ST_WAIT: begin
                    if (!slice_bus.result_valid) begin
                        state_r <= ST_WAIT;
                    end else if (slice_index_r == LAST_SLICE) begin
                        state_r      <= ST_DONE;
                        frame_done_r <= 1'b1;
                    end else begin
                        state_r       <= ST_ISSUE;
                        slice_valid_r <= 1'b1;
                        slice_index_r <= slice_index_r + 8'd1;
                        ray_int_r     <= int_next_s;
                        ray_frac_r    <= frac_next_s;
                    end
                end
                ST_DONE: begin
                    state_r      <= ST_IDLE;
                    frame_done_r <= 1'b0;
                    busy_r       <= 1'b0;
                end
                default: begin
                    state_r       <= ST_IDLE;
                    slice_valid_r <= 1'b0;
                    busy_r        <= 1'b0;
                    frame_done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign slice_bus.slice_valid    = slice_valid_r;
    assign slice_bus.slice_index    = slice_index_r;
    assign slice_bus.ray_angle_int  = ray_int_r;
    assign slice_bus.ray_angle_frac = ray_frac_r;
    assign busy                     = busy_r;
    assign frame_done               = frame_done_r;

endmodule

// File: tb/tb_ray_slice_sequencer.sv
// Bench for ray_slice_sequencer: table of known slice angles, hand-built corner frames and randomized
// handshake timing checked against an absolute (non-incremental) angle model.
module tb_ray_slice_sequencer;

    localparam int N            = 160;
    localparam int HALF_FOV     = 30;
    localparam int STEP_MILLI   = 375;
    localparam int CIRCLE_MILLI = 360000;
    localparam int BUDGET       = 5000;

    logic       clock = 1'b0;
    logic       reset;
    logic       frame_start;
    logic [8:0] player_angle;
    logic       busy;
    logic       frame_done;

    ray_slice_sequencer_if bus ();

    ray_slice_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .frame_start  (frame_start),
        .player_angle (player_angle),
        .busy         (busy),
        .frame_done   (frame_done),
        .slice_bus    (bus)
    );

    always #5 clock = ~clock;

    int vec_cnt = 0;
    int err_cnt = 0;
    int got_milli [N];

    typedef struct {
        int pa;
        int slice;
        int e_int;
        int e_frac;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Angle of slice k in thousandths of a degree, computed directly rather than by stepping.
    function automatic int model_milli(input int pa, input int k);
        int start;
        start = (pa - HALF_FOV + 360) % 360;
        return (start * 1000 + k * STEP_MILLI) % CIRCLE_MILLI;
    endfunction

    // Runs one frame acting as the datapath; rnd randomizes ready and result latency.
    task automatic run_frame(input int pa, input bit rnd, input int stall_slice, input bit inject_fs,
                             input int abort_slice, output int done_cyc);
        int cyc, exp_slice, res_wait, stall_left, snap, cur;
        bit in_flight, prev_valid, finished, fs_sent, done_expected, done_seen;
        cyc = 0; exp_slice = 0; res_wait = 0; stall_left = 0; snap = 0;
        in_flight = 0; prev_valid = 0; finished = 0; fs_sent = 0;
        done_expected = 0; done_seen = 0;
        done_cyc = -1;
        player_angle = 9'(pa);
        frame_start = 1'b1;
        bus.slice_ready = 1'b0;
        bus.result_valid = 1'b0;
        tick();
        frame_start = 1'b0;
        player_angle = 9'((pa + 123) % 360);
        cyc = 1;
        while (!finished && cyc < BUDGET) begin
            bus.result_valid = 1'b0;
            frame_start = 1'b0;
            cur = int'({bus.slice_index, bus.ray_angle_int, bus.ray_angle_frac});
            if (done_seen) begin
                chk("busy_after_done", int'(busy), 0);
                chk("done_single_pulse", int'(frame_done), 0);
                finished = 1;
            end else begin
                chk("busy_in_frame", int'(busy), 1);
                if (done_expected) begin
                    chk("frame_done_pulse", int'(frame_done), 1);
                    chk("valid_low_in_done", int'(bus.slice_valid), 0);
                    done_seen = 1;
                    done_cyc = cyc;
                end else begin
                    chk("frame_done_early", int'(frame_done), 0);
                end
                if (done_expected) begin
                    bus.slice_ready = 1'b1;
                end else if (in_flight) begin
                    chk("valid_low_in_wait", int'(bus.slice_valid), 0);
                    if (inject_fs && exp_slice == 10 && !fs_sent) begin
                        frame_start = 1'b1;
                        player_angle = 9'((pa + 77) % 360);
                        fs_sent = 1;
                    end
                    if (res_wait == 0) begin
                        bus.result_valid = 1'b1;
                        in_flight = 0;
                        if (exp_slice == N - 1) done_expected = 1;
                        else exp_slice++;
                    end else begin
                        res_wait--;
                    end
                end else if (bus.slice_valid) begin
                    if (!prev_valid) begin
                        chk("slice_index", int'(bus.slice_index), exp_slice);
                        chk("angle_milli", int'(bus.ray_angle_int) * 1000 + int'(bus.ray_angle_frac),
                            model_milli(pa, exp_slice));
                        got_milli[exp_slice] = int'(bus.ray_angle_int) * 1000 + int'(bus.ray_angle_frac);
                        if (!rnd && stall_slice < 0) chk("issue_cycle", cyc, 1 + 2 * exp_slice);
                        snap = cur;
                        if (exp_slice == stall_slice) stall_left = 5;
                        if (exp_slice == abort_slice) finished = 1;
                    end else begin
                        chk("held_stable", cur, snap);
                    end
                    if (stall_left > 0) begin
                        bus.slice_ready = 1'b0;
                        stall_left--;
                    end else if (rnd) begin
                        bus.slice_ready = 1'($urandom_range(0, 1));
                    end else begin
                        bus.slice_ready = 1'b1;
                    end
                    if (bus.slice_ready && !finished) begin
                        in_flight = 1;
                        res_wait = rnd ? int'($urandom_range(0, 2)) : 0;
                    end
                end else begin
                    chk("valid_after_result", int'(bus.slice_valid), 1);
                end
            end
            if (!finished) begin
                prev_valid = bus.slice_valid;
                tick();
                cyc++;
            end
        end
        chk("frame_timeout", int'(finished), 1);
    endtask

    initial begin
        int dc;
        int pas [3];
        vecs[0] = '{90, 0, 60, 0};
        vecs[1] = '{90, 1, 60, 375};
        vecs[2] = '{90, 8, 63, 0};
        vecs[3] = '{90, 159, 119, 625};
        vecs[4] = '{10, 0, 340, 0};
        vecs[5] = '{10, 79, 9, 625};
        vecs[6] = '{10, 80, 10, 0};
        vecs[7] = '{359, 0, 329, 0};
        vecs[8] = '{359, 82, 359, 750};
        vecs[9] = '{359, 83, 0, 125};
        pas[0] = 90; pas[1] = 10; pas[2] = 359;

        reset = 1'b1;
        frame_start = 1'b0;
        player_angle = 9'd0;
        bus.slice_ready = 1'b0;
        bus.result_valid = 1'b0;
        repeat (3) tick();
        chk("rst_valid", int'(bus.slice_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(frame_done), 0);
        chk("rst_index", int'(bus.slice_index), 0);
        chk("rst_int", int'(bus.ray_angle_int), 0);
        chk("rst_frac", int'(bus.ray_angle_frac), 0);
        reset = 1'b0;

        bus.result_valid = 1'b1;
        tick();
        bus.result_valid = 1'b0;
        tick();
        chk("idle_result_valid", int'(bus.slice_valid), 0);
        chk("idle_busy", int'(busy), 0);

        for (int p = 0; p < 3; p++) begin
            run_frame(pas[p], 1'b0, -1, 1'b0, -1, dc);
            chk("done_cycle", dc, 2 * N + 1);
            for (int i = 0; i < 10; i++) begin
                if (vecs[i].pa == pas[p]) begin
                    chk($sformatf("table_pa%0d_s%0d", vecs[i].pa, vecs[i].slice),
                        got_milli[vecs[i].slice], vecs[i].e_int * 1000 + vecs[i].e_frac);
                end
            end
        end

        run_frame(200, 1'b0, 3, 1'b0, -1, dc);
        chk("stall_done_cycle", dc, 2 * N + 1 + 5);

        run_frame(45, 1'b0, -1, 1'b1, -1, dc);
        chk("ignored_start_done_cycle", dc, 2 * N + 1);

        run_frame(123, 1'b0, -1, 1'b0, 50, dc);
        reset = 1'b1;
        bus.slice_ready = 1'b1;
        tick();
        reset = 1'b0;
        bus.slice_ready = 1'b0;
        chk("midrst_valid", int'(bus.slice_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_index", int'(bus.slice_index), 0);
        chk("midrst_angle", int'(bus.ray_angle_int) * 1000 + int'(bus.ray_angle_frac), 0);
        tick();
        run_frame(250, 1'b0, -1, 1'b0, -1, dc);
        chk("after_rst_done_cycle", dc, 2 * N + 1);

        for (int r = 0; r < 4; r++) begin
            run_frame(int'($urandom_range(0, 359)), 1'b1, -1, 1'b0, -1, dc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/ray_slice_sequencer.md
Name: ray_slice_sequencer

Overview:
Per-frame column scheduler for the raycaster. On a frame start it sweeps screen slices 0..NUM_SLICES-1. For each slice it computes the ray angle as a decimal fixed-point pair: an integer in degrees plus a fraction in thousandths, using an incremental 0.375° step. It issues one request per slice to the shared ray/distance datapath and waits for that slice's result before issuing the next. It sits between the frame timing logic and the fixed-point ray arithmetic.

Parameters:
NUM_SLICES, 160, slices per frame (screen width).
FOV_DEG, 60, field of view in whole degrees; must be even.
STEP_INT, 0, integer part of per-slice angle step (degrees).
STEP_FRAC, 375, fractional part of step in thousandths; must be < FRAC_SCALE.
FRAC_SCALE, 1000, fraction denominator (3 d.p.).

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
frame_start  in  1  single-cycle pulse; starts a sweep when idle
player_angle  in  9  player heading, integer degrees 0..359; sampled on accepted frame_start
slice_valid  out  1  request valid to ray datapath
slice_ready  in  1  datapath accepts request
slice_index  out  8  current slice number 0..NUM_SLICES-1
ray_angle_int  out  9  ray angle integer degrees 0..359
ray_angle_frac  out  10  ray angle fraction, thousandths 0..FRAC_SCALE-1
result_valid  in  1  datapath finished the outstanding slice (1-cycle pulse)
busy  out  1  high from the cycle after accepted frame_start through DONE
frame_done  out  1  single-cycle pulse when the last slice's result is returned

Behaviour:
- Reset: state IDLE. slice_valid=0, busy=0, frame_done=0, slice_index=0, ray_angle_int=0, ray_angle_frac=0. Reset has priority over every other input in any state, including mid-frame. The next frame restarts from slice 0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: frame_start=1 → ISSUE.
  - Same edge: slice_index←0, ray_angle_frac←0, ray_angle_int←player_angle−FOV_DEG/2, plus 360 if the result is negative.
  - player_angle is not sampled again until the next frame.
- ISSUE: slice_valid=1, busy=1. slice_index and the angle outputs are stable while valid is high.
  - slice_ready=0: remain in ISSUE; valid stays high and outputs do not change.
  - slice_ready=1: transfer → WAIT.
- WAIT: slice_valid=0. result_valid=1:
  - If slice_index==NUM_SLICES−1 → DONE.
  - Otherwise → ISSUE, slice_index+1, angle advanced by one step.
  - result_valid in IDLE, ISSUE or DONE is ignored.
- Angle advance, registered, no multiplier:
  - f = frac + STEP_FRAC. If f ≥ FRAC_SCALE: frac←f−FRAC_SCALE and carry=1; else frac←f and carry=0.
  - i = int + STEP_INT + carry. If i ≥ 360: int←i−360; else int←i.
  - Internal sums use widths that cannot overflow: 11 bits for the fraction, 10 bits for the integer.
- DONE: frame_done=1 for exactly one cycle, busy=1. Then → IDLE with busy=0. Outputs hold their last slice values.
- frame_start while busy (ISSUE, WAIT or DONE) is ignored. It is not queued.
- Throughput: at most one outstanding request; next issue occurs ≥1 cycle after result_valid.
- Minimum frame latency (slice_ready tied high, result_valid one cycle after each transfer):
  - frame_start sampled at cycle 0.
  - Slice k issues at cycle 1+2k.
  - frame_done at cycle 2·NUM_SLICES+1, which is 321 for defaults.

Test Plan:
- player_angle=90, frame_start, slice_ready=1, result_valid 1 cycle after each transfer → slice 0 = 60.000, slice 1 = 60.375, slice 8 = 63.000, slice 159 = 119.625. frame_done pulses once at cycle 321; busy falls the cycle after.
- Low wrap: player_angle=10 → slice 0 = 340.000; slice 79 = 369.625−360 = 9.625; slice 80 = 10.000.
- High wrap: player_angle=359 → slice 0 = 329.000; slice 82 = 359.750; slice 83 = 0.125.
- Backpressure: hold slice_ready=0 for 5 cycles on slice 3 → slice_valid stays 1; index and angle are unchanged. The transfer occurs on the first ready cycle, and there is no duplicate issue.
- frame_start pulsed during WAIT of slice 10 with a different player_angle → ignored. Slice 11 continues the original angle sequence, and a single frame_done occurs.
- reset asserted during ISSUE of slice 50 → next cycle slice_valid=0, busy=0, all outputs 0. A following frame_start restarts at slice 0 with the correct angle.
